uart_tx_fifo_drain: RTL

//  UART transmitter that drains a first-word-fall-through (FWFT) byte FIFO and serialises each byte as 8N1.

---
 rtl/uart_tx_fifo_drain.sv | 104 ++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_drain.sv
// 8N1 UART transmitter that pops bytes from a first-word-fall-through FIFO.
// Exactly one pop per frame; a new pop can occur in the tx_done cycle.
module uart_tx_fifo_drain #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int BW  = $clog2(CLKS_PER_BIT);
   localparam int BCW = $clog2(DATA_WIDTH) + 1;
   localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   localparam logic [BCW-1:0] BIT_MAX  = BCW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t                state;
   logic [BW-1:0]         baud_cnt;
   logic [BCW-1:0]        bit_cnt;
   logic [DATA_WIDTH-1:0] shift;
   logic [DATA_WIDTH-1:0] shift_nxt;
   logic                  bit_end;

   assign shift_nxt  = shift >> 1;
   assign bit_end    = (baud_cnt == BAUD_MAX);
   // Pop only from IDLE, so the late empty flag can never cause a double pop
   assign fifo_rd_en = !rst && (state == IDLE) && tx_en && !fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (fifo_rd_en) begin
                  shift <= fifo_dout;
                  state <= START;
                  tx    <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= DATA;
                  tx       <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == BIT_MAX) begin
                     bit_cnt <= '0;
                     state   <= STOP;
                     tx      <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + BCW'(1);
                     shift   <= shift_nxt;
                     tx      <= shift_nxt[0];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
                  busy     <= 1'b0;
                  tx_done  <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
